// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ctrl_pkg : opcode/funct constants, ALU and next-PC codes, FSM state encoding
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_SLLI = 6'h05;
    localparam logic [5:0] OP_SRLI = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BLT  = 6'h09;
    localparam logic [5:0] OP_BNE  = 6'h0B;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] FN_OR  = 6'h13;
    localparam logic [5:0] FN_XOR = 6'h14;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_BRANCH = 3'b011;
    localparam logic [2:0] PC_TRAP   = 3'b110;
    localparam logic [2:0] PC_HALT   = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef struct packed {
        logic       is_r;
        logic       is_j;
        logic       is_beq;
        logic       is_bne;
        logic       is_blt;
        logic       is_lw;
        logic       is_sw;
        logic       is_halt;
        logic       alu_src;
        logic       reg_wb;
        logic       illegal;
        logic [3:0] alu_ctrl;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode : combinational instruction-register to control-field decoder
// Revision    : 1.0
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] ir_i,
    output dec_t               dec_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_mid;

    assign opcode     = ir_i[INSTR_W-1 -: 6];
    assign funct      = ir_i[5:0];
    assign unused_mid = ^ir_i[INSTR_W-7:6];

    always_comb begin
        dec_o          = '0;
        dec_o.alu_ctrl = ALU_NONE;
        case (opcode)
            OP_R: begin
                dec_o.is_r   = 1'b1;
                dec_o.reg_wb = 1'b1;
                case (funct)
                    FN_OR:   dec_o.alu_ctrl = ALU_OR;
                    FN_ADD:  dec_o.alu_ctrl = ALU_ADD;
                    FN_XOR:  dec_o.alu_ctrl = ALU_XOR;
                    FN_SUB:  dec_o.alu_ctrl = ALU_SUB;
                    default: dec_o.alu_ctrl = ALU_NONE;
                endcase
            end
            OP_J:    dec_o.is_j = 1'b1;
            OP_BEQ:  begin dec_o.is_beq = 1'b1; dec_o.alu_ctrl = ALU_SUB; end
            OP_BNE:  begin dec_o.is_bne = 1'b1; dec_o.alu_ctrl = ALU_SUB; end
            OP_BLT:  begin dec_o.is_blt = 1'b1; dec_o.alu_ctrl = ALU_SUB; end
            OP_SLLI: begin dec_o.alu_src = 1'b1; dec_o.reg_wb = 1'b1; dec_o.alu_ctrl = ALU_SLL; end
            OP_SRLI: begin dec_o.alu_src = 1'b1; dec_o.reg_wb = 1'b1; dec_o.alu_ctrl = ALU_SRL; end
            OP_ADDI: begin dec_o.alu_src = 1'b1; dec_o.reg_wb = 1'b1; dec_o.alu_ctrl = ALU_ADD; end
            OP_LW: begin
                dec_o.is_lw    = 1'b1;
                dec_o.alu_src  = 1'b1;
                dec_o.reg_wb   = 1'b1;
                dec_o.alu_ctrl = ALU_ADD;
            end
            OP_SW: begin
                dec_o.is_sw    = 1'b1;
                dec_o.alu_src  = 1'b1;
                dec_o.alu_ctrl = ALU_ADD;
            end
            OP_HALT: dec_o.is_halt = 1'b1;
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm_mc.sv
`default_nettype none
// ============================================================================
// ctrl_fsm_mc : multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT/TRAP)
// Option      : CTRL_ILLEGAL_TRAP_EN -> illegal opcode or MEM timeout enters TRAP
// Revision    : 1.0
// ============================================================================
module ctrl_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               alu_zero,
    input  logic               alu_neg,
    output logic               instr_req,
    output logic               mem_req,
    output logic               MemRW,
    output logic               regWrite,
    output logic               memReg,
    output logic               regDst,
    output logic               ALUSrc,
    output logic               pc_write,
    output logic [3:0]         alu_control,
    output logic [2:0]         pc_control,
    output logic               halted,
    output logic [2:0]         state
);

    localparam int          CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    state_e             state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   wait_q;
    logic               instr_req_q, mem_req_q, memrw_q, regwrite_q, memreg_q;
    logic               regdst_q, alusrc_q, pc_write_q, halted_q;
    logic [3:0]         alu_ctrl_q;
    logic [2:0]         pc_ctrl_q;

    dec_t       dec;
    logic [6:0] st_oh;
    logic       taken, timeout, hold, exec_retire;

    ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign st_oh   = 7'b1 << state_q;
    assign taken   = (dec.is_beq & alu_zero) | (dec.is_bne & ~alu_zero) | (dec.is_blt & alu_neg);
    assign timeout = TO_EN && (32'(wait_q) == TO_LAST);
    assign hold    = st_oh[S_EXEC] | st_oh[S_MEM] | st_oh[S_WB];
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign exec_retire = dec.is_j | dec.is_beq | dec.is_bne | dec.is_blt;
`else
    assign exec_retire = dec.is_j | dec.is_beq | dec.is_bne | dec.is_blt | dec.illegal;
`endif

    // Branch outcome and store completion depend on same-cycle inputs, so only
    // those two terms bypass the output registers.
    assign pc_write    = pc_write_q | (st_oh[S_MEM] & dec.is_sw & mem_ready);
    assign pc_control  = (st_oh[S_EXEC] && taken) ? PC_BRANCH : pc_ctrl_q;
    assign alu_control = hold ? alu_ctrl_q : ALU_NONE;
    assign ALUSrc      = hold & alusrc_q;
    assign regDst      = hold & regdst_q;
    assign instr_req   = instr_req_q;
    assign mem_req     = mem_req_q;
    assign MemRW       = memrw_q;
    assign regWrite    = regwrite_q;
    assign memReg      = memreg_q;
    assign halted      = halted_q;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            wait_q      <= '0;
            instr_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            memrw_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memreg_q    <= 1'b0;
            regdst_q    <= 1'b0;
            alusrc_q    <= 1'b0;
            pc_write_q  <= 1'b0;
            halted_q    <= 1'b0;
            alu_ctrl_q  <= ALU_NONE;
            pc_ctrl_q   <= PC_SEQ;
        end else begin
            instr_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            memrw_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memreg_q    <= 1'b0;
            pc_write_q  <= 1'b0;
            pc_ctrl_q   <= PC_SEQ;
            case (1'b1)
                st_oh[S_FETCH]: begin
                    // The first cycle out of reset only raises the request.
                    if (instr_req_q && instr_valid) begin
                        ir_q    <= instr_in;
                        state_q <= S_DECODE;
                    end else begin
                        instr_req_q <= 1'b1;
                    end
                end
                st_oh[S_DECODE]: begin
                    state_q    <= S_EXEC;
                    alu_ctrl_q <= dec.alu_ctrl;
                    alusrc_q   <= dec.alu_src;
                    regdst_q   <= dec.is_r;
                    pc_write_q <= exec_retire;
                    pc_ctrl_q  <= dec.is_j ? PC_JUMP : PC_SEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    if (dec.illegal) begin
                        state_q   <= S_TRAP;
                        halted_q  <= 1'b1;
                        pc_ctrl_q <= PC_TRAP;
                    end
`endif
                end
                st_oh[S_EXEC]: begin
                    if (dec.is_lw || dec.is_sw) begin
                        state_q   <= S_MEM;
                        wait_q    <= '0;
                        mem_req_q <= 1'b1;
                        memrw_q   <= dec.is_sw;
                    end else if (dec.is_halt) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        pc_ctrl_q <= PC_HALT;
                    end else if (dec.reg_wb) begin
                        state_q    <= S_WB;
                        regwrite_q <= 1'b1;
                        pc_write_q <= 1'b1;
                    end else begin
                        state_q     <= S_FETCH;
                        instr_req_q <= 1'b1;
                    end
                end
                st_oh[S_MEM]: begin
                    if (mem_ready) begin
                        if (dec.is_lw) begin
                            state_q    <= S_WB;
                            regwrite_q <= 1'b1;
                            memreg_q   <= 1'b1;
                            pc_write_q <= 1'b1;
                        end else begin
                            state_q     <= S_FETCH;
                            instr_req_q <= 1'b1;
                        end
                    end else if (timeout) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_q   <= S_TRAP;
                        halted_q  <= 1'b1;
                        pc_ctrl_q <= PC_TRAP;
`else
                        state_q     <= S_FETCH;
                        instr_req_q <= 1'b1;
`endif
                    end else begin
                        wait_q    <= wait_q + 1'b1;
                        mem_req_q <= 1'b1;
                        memrw_q   <= dec.is_sw;
                    end
                end
                st_oh[S_WB]: begin
                    state_q     <= S_FETCH;
                    instr_req_q <= 1'b1;
                end
                st_oh[S_HALT]: begin
                    halted_q  <= 1'b1;
                    pc_ctrl_q <= PC_HALT;
                end
                st_oh[S_TRAP]: begin
                    halted_q  <= 1'b1;
                    pc_ctrl_q <= PC_TRAP;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
